// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller between four ports, each with
// a write and a read slot (eight slots), and serves one burst at a time.
//
// state | meaning
// IDLE  | nothing in flight; leave once init is done and some slot requests
// ARB   | one cycle: pick the next requesting slot after r_last, latch addr/bl
// REQ   | controller request held high until the first matching ack
// XFER  | data phase; grant follows the matching ack
// DONE  | one cycle: remember the served slot, re-arbitrate or go idle
module sdram_port_arbiter #(
    parameter int ADDR_W = 24,
    parameter int BL_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_init_done,
    input  logic [3:0]            i_port_wr_req,
    input  logic [3:0]            i_port_rd_req,
    input  logic [4*ADDR_W-1:0]   i_port_wr_addr,
    input  logic [4*ADDR_W-1:0]   i_port_rd_addr,
    input  logic [4*BL_W-1:0]     i_port_wr_bl,
    input  logic [4*BL_W-1:0]     i_port_rd_bl,
    output logic [3:0]            o_port_wr_grant,
    output logic [3:0]            o_port_rd_grant,
    output logic                  o_ctrl_wr_req,
    output logic                  o_ctrl_rd_req,
    output logic [ADDR_W-1:0]     o_ctrl_addr,
    output logic [BL_W-1:0]       o_ctrl_bl,
    input  logic                  i_ctrl_wr_ack,
    input  logic                  i_ctrl_rd_ack,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        REQ  = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_last;
    logic [1:0]          r_sel_port;
    logic                r_sel_dir;
    logic [ADDR_W-1:0]   r_addr;
    logic [BL_W-1:0]     r_bl;
    logic                r_ctrl_wr_req;
    logic                r_ctrl_rd_req;

    logic [7:0]          w_slot_req;
    logic                w_any_req;
    logic                w_win_found;
    logic [2:0]          w_win_slot;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [BL_W-1:0]     w_win_bl;
    logic                w_ack_sel;

    always_comb begin
        w_slot_req = '0;
        for (int p = 0; p < 4; p++) begin
            w_slot_req[2*p]   = i_port_wr_req[p];
            w_slot_req[2*p+1] = i_port_rd_req[p];
        end
    end

    assign w_any_req = |w_slot_req;

    // Search starts one past the last served slot; 3-bit add wraps mod 8.
    always_comb begin
        logic [2:0] v_idx;
        v_idx       = '0;
        w_win_found = 1'b0;
        w_win_slot  = '0;
        for (int i = 1; i <= 8; i++) begin
            v_idx = r_last + 3'(i);
            if (!w_win_found && w_slot_req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_slot  = v_idx;
            end
        end
    end

    always_comb begin
        w_win_addr = '0;
        w_win_bl   = '0;
        for (int p = 0; p < 4; p++) begin
            if (w_win_slot[2:1] == 2'(p)) begin
                w_win_addr = w_win_slot[0] ? i_port_rd_addr[p*ADDR_W +: ADDR_W]
                                           : i_port_wr_addr[p*ADDR_W +: ADDR_W];
                w_win_bl   = w_win_slot[0] ? i_port_rd_bl[p*BL_W +: BL_W]
                                           : i_port_wr_bl[p*BL_W +: BL_W];
            end
        end
    end

    assign w_ack_sel = r_sel_dir ? i_ctrl_rd_ack : i_ctrl_wr_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // init_done only gates leaving IDLE; DONE re-arbitrates regardless.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_init_done && w_any_req) w_next_state = ARB;
            ARB:     w_next_state = w_win_found ? REQ : IDLE;
            REQ:     if (w_ack_sel) w_next_state = XFER;
            XFER:    if (!w_ack_sel) w_next_state = DONE;
            DONE:    w_next_state = w_any_req ? ARB : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last        <= 3'd7;
            r_sel_port    <= '0;
            r_sel_dir     <= 1'b0;
            r_addr        <= '0;
            r_bl          <= '0;
            r_ctrl_wr_req <= 1'b0;
            r_ctrl_rd_req <= 1'b0;
        end else begin
            if (r_state == ARB && w_win_found) begin
                r_sel_port    <= w_win_slot[2:1];
                r_sel_dir     <= w_win_slot[0];
                r_addr        <= w_win_addr;
                r_bl          <= w_win_bl;
                r_ctrl_wr_req <= ~w_win_slot[0];
                r_ctrl_rd_req <= w_win_slot[0];
            end else if (r_state == REQ && w_ack_sel) begin
                r_ctrl_wr_req <= 1'b0;
                r_ctrl_rd_req <= 1'b0;
            end
            if (r_state == DONE) r_last <= {r_sel_port, r_sel_dir};
        end
    end

    // Grants are combinational from the ack so the port FIFO sees them in the data cycle.
    always_comb begin
        o_port_wr_grant = '0;
        o_port_rd_grant = '0;
        if (r_state == REQ || r_state == XFER) begin
            if (!r_sel_dir && i_ctrl_wr_ack) o_port_wr_grant[r_sel_port] = 1'b1;
            if (r_sel_dir && i_ctrl_rd_ack)  o_port_rd_grant[r_sel_port] = 1'b1;
        end
        o_busy = (r_state != IDLE);
    end

    assign o_ctrl_wr_req = r_ctrl_wr_req;
    assign o_ctrl_rd_req = r_ctrl_rd_req;
    assign o_ctrl_addr   = r_addr;
    assign o_ctrl_bl     = r_bl;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a hand-driven controller model acks each
// burst and the expected slot, address, grants and gaps are checked cycle by cycle.
module tb_sdram_port_arbiter;
    localparam int AW = 24;
    localparam int BW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              init_done;
    logic [3:0]        wr_req, rd_req;
    logic [4*AW-1:0]   wr_addr, rd_addr;
    logic [4*BW-1:0]   wr_bl, rd_bl;
    logic [3:0]        wr_grant, rd_grant;
    logic              ctrl_wr_req, ctrl_rd_req;
    logic [AW-1:0]     ctrl_addr;
    logic [BW-1:0]     ctrl_bl;
    logic              ctrl_wr_ack, ctrl_rd_ack;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;

    sdram_port_arbiter #(.ADDR_W(AW), .BL_W(BW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_init_done     (init_done),
        .i_port_wr_req   (wr_req),
        .i_port_rd_req   (rd_req),
        .i_port_wr_addr  (wr_addr),
        .i_port_rd_addr  (rd_addr),
        .i_port_wr_bl    (wr_bl),
        .i_port_rd_bl    (rd_bl),
        .o_port_wr_grant (wr_grant),
        .o_port_rd_grant (rd_grant),
        .o_ctrl_wr_req   (ctrl_wr_req),
        .o_ctrl_rd_req   (ctrl_rd_req),
        .o_ctrl_addr     (ctrl_addr),
        .o_ctrl_bl       (ctrl_bl),
        .i_ctrl_wr_ack   (ctrl_wr_ack),
        .i_ctrl_rd_ack   (ctrl_rd_ack),
        .o_busy          (busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] f_addr(input int p, input bit dir);
        return dir ? AW'(24'h400000 + 24'h1000 * (p + 1)) : AW'(24'h1000 * (p + 1));
    endfunction

    function automatic logic [BW-1:0] f_bl(input int p, input bit dir);
        if (dir) return (p == 2) ? BW'(16) : BW'(8 + p);
        return BW'(4 + p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_wr_req || ctrl_rd_req) seen = 1'b1;
        end
        check("req_seen", 64'(seen), 64'd1);
    endtask

    // Serve one burst of n ack cycles for the expected slot (port p, dir 0=wr 1=rd).
    task automatic serve(input int p, input bit dir, input int n, input int drop_at,
                         input bit drop_all, input int spur_at);
        bit         seen;
        logic [3:0] oh;
        oh = 4'b0001 << p;
        wait_req(seen);
        if (!seen) return;
        check($sformatf("wr_req p%0d d%0d", p, dir), 64'(ctrl_wr_req), 64'(!dir));
        check($sformatf("rd_req p%0d d%0d", p, dir), 64'(ctrl_rd_req), 64'(dir));
        check($sformatf("addr p%0d d%0d", p, dir), 64'(ctrl_addr), 64'(f_addr(p, dir)));
        check($sformatf("bl p%0d d%0d", p, dir), 64'(ctrl_bl), 64'(f_bl(p, dir)));
        check("grant_before_ack", 64'({wr_grant, rd_grant}), 64'd0);
        tick();
        if (dir) ctrl_rd_ack = 1'b1;
        else     ctrl_wr_ack = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (c == drop_at) begin
                if (drop_all) begin
                    wr_req = '0;
                    rd_req = '0;
                end else if (dir) rd_req[p] = 1'b0;
                else              wr_req[p] = 1'b0;
            end
            if (c == spur_at) ctrl_wr_ack = 1'b1;
            @(negedge clk);
            check($sformatf("wr_grant p%0d c%0d", p, c), 64'(wr_grant), 64'(dir ? 4'b0000 : oh));
            check($sformatf("rd_grant p%0d c%0d", p, c), 64'(rd_grant), 64'(dir ? oh : 4'b0000));
            if (c >= 1)
                check("req_low_in_xfer", 64'({ctrl_wr_req, ctrl_rd_req}), 64'd0);
            tick();
            if (c == spur_at) ctrl_wr_ack = 1'b0;
        end
        ctrl_wr_ack = 1'b0;
        ctrl_rd_ack = 1'b0;
        @(negedge clk);
        check("grant_after_ack", 64'({wr_grant, rd_grant}), 64'd0);
        check("busy_after_ack", 64'(busy), 64'd1);
    endtask

    // Counts req-low cycles after the edge that samples the ack low (DONE, ARB).
    task automatic measure_gap(output int g);
        bit seen;
        seen = 1'b0;
        g = 0;
        @(posedge clk);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_wr_req || ctrl_rd_req) seen = 1'b1;
            else g++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int g;
        init_done   = 1'b0;
        wr_req      = '0;
        rd_req      = '0;
        ctrl_wr_ack = 1'b0;
        ctrl_rd_ack = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wr_addr[p*AW +: AW] = f_addr(p, 1'b0);
            rd_addr[p*AW +: AW] = f_addr(p, 1'b1);
            wr_bl[p*BW +: BW]   = f_bl(p, 1'b0);
            rd_bl[p*BW +: BW]   = f_bl(p, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({wr_grant, rd_grant, ctrl_wr_req, ctrl_rd_req, ctrl_addr, ctrl_bl}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // T1: request ignored until init_done, then ctrl req two edges later
        wr_req = 4'b0001;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ctrl_wr_req || ctrl_rd_req || busy) seen = 1'b1;
        end
        check("t1_no_req_before_init", 64'(seen), 64'd0);
        tick();
        init_done = 1'b1;
        @(negedge clk);
        check("t1_req_edge0", 64'({ctrl_wr_req, ctrl_rd_req}), 64'd0);
        @(negedge clk);
        check("t1_req_edge1", 64'({ctrl_wr_req, ctrl_rd_req}), 64'd0);
        check("t1_busy_arb", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_req_edge2", 64'({ctrl_wr_req, ctrl_rd_req}), 64'b10);
        check("t1_addr", 64'(ctrl_addr), 64'(f_addr(0, 1'b0)));
        serve(0, 1'b0, 4, 1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("t1_idle", 64'(busy), 64'd0);

        // T2: all slots requesting -> full round-robin order, then wr0 again
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wr_req = 4'hF;
        rd_req = 4'hF;
        for (int k = 0; k < 9; k++)
            serve((k % 8) / 2, bit'(k % 2), 4, (k == 8) ? 1 : -1, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("t2_idle", 64'(busy), 64'd0);

        // T3/T4: repeated rd bursts to port 2, 2-cycle gap, spurious wr ack ignored
        tick();
        rd_req = 4'b0100;
        serve(2, 1'b1, 8, -1, 1'b0, 3);
        measure_gap(g);
        check("t3_gap1", 64'(g), 64'd2);
        serve(2, 1'b1, 8, -1, 1'b0, -1);
        measure_gap(g);
        check("t3_gap2", 64'(g), 64'd2);
        serve(2, 1'b1, 8, 4, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("t3_idle", 64'(busy), 64'd0);
        tick();
        ctrl_wr_ack = 1'b1;
        @(negedge clk);
        check("t4_idle_spur_wr", 64'(wr_grant), 64'd0);
        tick();
        ctrl_wr_ack = 1'b0;

        // T5: wr1 withdrawn mid-burst; init_done drop after arbitration is ignored
        wr_req = 4'b0010;
        rd_req = 4'b0010;
        serve(1, 1'b0, 6, 2, 1'b0, -1);
        init_done = 1'b0;
        serve(1, 1'b1, 4, 1, 1'b0, -1);
        init_done = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle", 64'(busy), 64'd0);

        // T6: async reset in XFER of wr3, then first service is wr0
        tick();
        wr_req = 4'b1000;
        wait_req(seen);
        check("t6_addr", 64'(ctrl_addr), 64'(f_addr(3, 1'b0)));
        tick();
        ctrl_wr_ack = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", 64'({wr_grant, rd_grant, ctrl_wr_req, ctrl_rd_req, ctrl_addr, ctrl_bl}), 64'd0);
        check("t6_reset_busy", 64'(busy), 64'd0);
        ctrl_wr_ack = 1'b0;
        wr_req = 4'hF;
        rd_req = 4'hF;
        tick();
        rst_n = 1'b1;
        serve(0, 1'b0, 4, 1, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("t6_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
